// File: rtl/lut_breadboard_seq.sv
// Run-time programmable truth-table block: OUT_N tables of IN_W inputs, evaluated either one
// vector at a time (direct) or by an autonomous walk over every row (sweep).
module lut_breadboard_seq #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [(1<<IN_W)-1:0]   cfg_data,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IN_W-1:0]        out_idx,
  output logic [OUT_N-1:0]       out_vec,
  output logic                   busy,
  output logic                   done
);

  localparam int ROWS = 1 << IN_W;
  localparam logic [IN_W-1:0]  ROW_ZERO  = {IN_W{1'b0}};
  localparam logic [IN_W-1:0]  ROW_ONE   = IN_W'(1'b1);
  localparam logic [IN_W-1:0]  ROW_LAST  = {IN_W{1'b1}};
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W+1)'(OUT_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [ROWS-1:0]     table_r [OUT_N];
  logic [IN_W-1:0]     cnt_r;
  logic [IN_W-1:0]     out_idx_r;
  logic [OUT_N-1:0]    out_vec_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                done_r;

  logic                load_ok_s;
  logic                start_go_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                sweep_load_s;
  logic                load_s;
  logic                done_set_s;
  logic                cfg_hit_s;
  logic [IN_W-1:0]     row_s;
  logic [OUT_N-1:0]    row_vec_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; the load of the last row hands over to DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) state_nxt_s = ST_SWEEP;
        else            state_nxt_s = ST_IDLE;
      end
      ST_SWEEP: begin
        if (load_ok_s && (cnt_r == ROW_LAST)) state_nxt_s = ST_DONE;
        else                                  state_nxt_s = ST_SWEEP;
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) state_nxt_s = ST_IDLE;
        else                          state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, row selection and load strobes
  always_comb begin
    load_ok_s    = !out_valid_r || out_ready;
    start_go_s   = 1'b0;
    in_ready_s   = 1'b0;
    sweep_load_s = 1'b0;
    done_set_s   = 1'b0;
    row_s        = in_vec;
    case (state_r)
      ST_IDLE: begin
        // Row 0 goes out on the start edge itself so the sweep has the same latency as direct
        if (start && mode) begin
          start_go_s   = 1'b1;
          sweep_load_s = load_ok_s;
          row_s        = ROW_ZERO;
        end else begin
          in_ready_s   = load_ok_s;
          row_s        = in_vec;
        end
      end
      ST_SWEEP: begin
        sweep_load_s = load_ok_s;
        row_s        = cnt_r;
      end
      ST_DONE: begin
        done_set_s = out_valid_r && out_ready;
      end
      default: begin
        start_go_s = 1'b0;
      end
    endcase
    accept_s  = in_ready_s && in_valid;
    load_s    = sweep_load_s || accept_s;
    cfg_hit_s = cfg_we && !busy_r && ({1'b0, cfg_sel} < SEL_LIMIT);
  end

  // Table lookup for the selected row, using the tables as they stand this cycle
  always_comb begin
    row_vec_s = {OUT_N{1'b0}};
    for (int k = 0; k < OUT_N; k++) begin
      row_vec_s[k] = table_r[k][row_s];
    end
  end

  // Truth-table storage; whole-table writes only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_N; k++) begin
        table_r[k] <= {ROWS{1'b0}};
      end
    end else begin
      for (int k = 0; k < OUT_N; k++) begin
        if (cfg_hit_s && (cfg_sel == SEL_W'(k))) begin
          table_r[k] <= cfg_data;
        end
      end
    end
  end

  // Single-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= ROW_ZERO;
      out_vec_r   <= {OUT_N{1'b0}};
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= row_s;
      out_vec_r   <= row_vec_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sweep row counter, held at the last row instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= ROW_ZERO;
    end else if (start_go_s) begin
      cnt_r <= sweep_load_s ? ROW_ONE : ROW_ZERO;
    end else if ((state_r == ST_SWEEP) && sweep_load_s && (cnt_r != ROW_LAST)) begin
      cnt_r <= cnt_r + ROW_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Busy flag and one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= done_set_s;
      if (start_go_s)      busy_r <= 1'b1;
      else if (done_set_s) busy_r <= 1'b0;
      else                 busy_r <= busy_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_vec   = out_vec_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_lut_breadboard_seq.sv
// Scoreboard bench for lut_breadboard_seq: a table-level reference model predicts every output
// beat plus busy/done, and a negedge monitor compares whenever a beat transfers.
module tb_lut_breadboard_seq;

  localparam int IN_W  = 4;
  localparam int OUT_N = 10;
  localparam int SEL_W = 4;
  localparam int ROWS  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [ROWS-1:0]   cfg_data;
  logic              mode;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [IN_W-1:0]   out_idx;
  logic [OUT_N-1:0]  out_vec;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  lut_breadboard_seq #(.IN_W(IN_W), .OUT_N(OUT_N), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .mode(mode), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_vec(out_vec),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic             last;
    logic [IN_W-1:0]  idx;
    logic [OUT_N-1:0] vec;
  } beat_t;

  beat_t            sbq[$];
  logic [ROWS-1:0]  mtbl [OUT_N];
  int               n_checks = 0;
  int               n_pass   = 0;
  bit               exp_busy = 1'b0;
  bit               exp_done = 1'b0;
  bit               exp_valid_next = 1'b0;
  bit               hold_v = 1'b0;
  logic [IN_W-1:0]  hold_idx;
  logic [OUT_N-1:0] hold_vec;
  beat_t            m_e;
  bit               m_nb, m_nd, m_ld_ok, m_go, m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: output k of row r is simply bit r of table k
  function automatic logic [OUT_N-1:0] model_row(input logic [IN_W-1:0] r);
    logic [OUT_N-1:0] v;
    for (int k = 0; k < OUT_N; k++) v[k] = mtbl[k][r];
    return v;
  endfunction

  // Monitor + reference model, evaluated mid-cycle on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_vec", 32'(out_vec), 32'd0);
      sbq.delete();
      for (int k = 0; k < OUT_N; k++) mtbl[k] = '0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_valid_next = 1'b0; hold_v = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_valid_next) chk("load_latency", 32'(out_valid), 32'd1);
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_idx", 32'(out_idx), 32'(hold_idx));
        chk("hold_vec", 32'(out_vec), 32'(hold_vec));
      end
      m_ld_ok = !out_valid || out_ready;
      if (!mode || exp_busy || start)
        chk("in_ready", 32'(in_ready), 32'(!exp_busy && !(start && mode) && m_ld_ok));
      m_nb = exp_busy;
      m_nd = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          m_e = sbq.pop_front();
          chk("beat_idx", 32'(out_idx), 32'(m_e.idx));
          chk("beat_vec", 32'(out_vec), 32'(m_e.vec));
          if (m_e.last) begin m_nb = 1'b0; m_nd = 1'b1; end
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_idx = out_idx;
      hold_vec = out_vec;
      m_go  = start && mode && !exp_busy;
      m_acc = in_valid && !exp_busy && !(start && mode) && m_ld_ok;
      exp_valid_next = m_acc || (m_go && m_ld_ok);
      if (m_acc) sbq.push_back({1'b0, in_vec, model_row(in_vec)});
      if (m_go) begin
        for (int r = 0; r < ROWS; r++) sbq.push_back({(r == ROWS-1), 4'(r), model_row(4'(r))});
        m_nb = 1'b1;
      end
      if (cfg_we && !exp_busy && (cfg_sel < 4'd10)) mtbl[cfg_sel] = cfg_data;
      exp_busy = m_nb;
      exp_done = m_nd;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int sel, input logic [ROWS-1:0] data);
    cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic kick();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0; mode = 1'b0;
  endtask

  // bp: 0 = always ready, 1 = stall 3 cycles on row 5, 2 = random ready
  task automatic wait_done(input string nm, input int bp);
    int held = 0;
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        step();
        case (bp)
          1: begin
            if (out_valid && out_idx == 4'd5 && held < 3) begin out_ready = 1'b0; held++; end
            else out_ready = 1'b1;
          end
          2: out_ready = 1'($urandom_range(0, 3) != 0);
          default: out_ready = 1'b1;
        endcase
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (bp == 1) chk({nm, "_stall_cycles"}, 32'(held), 32'd3);
    out_ready = 1'b1;
    step();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b0; start = 1'b0; cfg_we = 1'b0; mode = 1'b0;
    while ((sbq.size() != 0 || exp_busy || done) && n < 200) begin step(); n++; end
    chk({nm, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; mode = 1'b0; start = 1'b0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    step();

    // T1: y&z table, direct evaluation of 0111
    cfg(4, 16'h8888);
    in_valid = 1'b1; in_vec = 4'b0111;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_idx", 32'(out_idx), 32'd7);
    chk("t1_vec4", 32'(out_vec[4]), 32'd1);
    step();

    // T2: full-rate sweep over random tables
    for (int k = 0; k < OUT_N; k++) cfg(k, 16'($urandom));
    kick();
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_idx", 32'(out_idx), 32'(i));
    end
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    step();

    // T3: backpressure on row 5
    kick();
    wait_done("t3", 1);

    // T4: same-cycle write vs accept, then write while busy
    cfg(0, 16'h0000);
    cfg_we = 1'b1; cfg_sel = 4'd0; cfg_data = 16'hFFFF; in_valid = 1'b1; in_vec = 4'd0;
    step();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("t4_same_cycle", 32'(out_vec[0]), 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_next_accept", 32'(out_vec[0]), 32'd1);
    step();
    kick();
    step();
    cfg(0, 16'h0000);
    wait_done("t4", 0);
    in_valid = 1'b1; in_vec = 4'd0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy_write_ignored", 32'(out_vec[0]), 32'd1);
    step();

    // T6: start, direct input and out-of-range write while busy
    kick();
    step();
    mode = 1'b1; start = 1'b1; in_valid = 1'b1; in_vec = 4'd3;
    cfg_we = 1'b1; cfg_sel = 4'd12; cfg_data = 16'hFFFF;
    step();
    mode = 1'b0; start = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    wait_done("t6", 2);
    cfg(12, 16'h1234);

    // Randomized mix of everything
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      mode      = start ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 7) == 0);
      in_valid  = (mode && !start) ? 1'b0 : 1'($urandom_range(0, 1));
      in_vec    = 4'($urandom);
      cfg_we    = !start && ($urandom_range(0, 5) == 0);
      cfg_sel   = 4'($urandom);
      cfg_data  = 16'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    drain("random");

    // T5: reset mid-sweep at row 8
    kick();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (out_valid && out_idx == 4'd8) found = 1'b1;
      else step();
    end
    chk("t5_reached_row8", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_valid_cleared", 32'(out_valid), 32'd0);
    chk("t5_busy_cleared", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    kick();
    wait_done("t5", 0);
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
